// File: rtl/systolic_scheduler_v2_pkg.sv
// Shared types and sizing helpers for the systolic scheduler.
package systolic_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    DONE    = 2'd3
  } sched_state_e;

  // Bits needed for the compute counter at its largest run:
  // (2^vec_w-1 + rows + cols - 2) * step - 1.
  function automatic int cnt_width(int rows, int cols, int step, int vec_w);
    int bound;
    bound = ((1 << vec_w) - 1 + rows + cols - 2) * step - 1;
    return (bound < 1) ? 1 : $clog2(bound + 1);
  endfunction

  // Length of the compute phase for n vectors.
  function automatic int calc_t(int n, int rows, int cols, int step);
    return (n + rows + cols - 2) * step;
  endfunction

endpackage

// File: rtl/systolic_scheduler_v2_if.sv
// Host/PE-grid handshake bundle of the scheduler.
interface systolic_scheduler_v2_if #(
  parameter int ROWS  = 2,
  parameter int VEC_W = 8
);
  logic             general_enable;
  logic             start;
  logic             abort;
  logic [VEC_W-1:0] num_vec;
  logic [ROWS-1:0]  load_weight;
  logic [ROWS-1:0]  enable_mult;
  logic             vec_req;
  logic             busy;
  logic             done;

  modport master (
    output general_enable, start, abort, num_vec,
    input  load_weight, enable_mult, vec_req, busy, done
  );

  modport slave (
    input  general_enable, start, abort, num_vec,
    output load_weight, enable_mult, vec_req, busy, done
  );
endinterface

// File: rtl/systolic_scheduler_v2_row_window_gen.sv
// Per-row multiply window: en = (R*STEP <= c < (R+N+COLS-1)*STEP).
// The upper bound is kept inclusive (hi-1) so it always fits in CW bits.
module row_window_gen #(
  parameter int R     = 0,
  parameter int COLS  = 2,
  parameter int STEP  = 4,
  parameter int CW    = 8,
  parameter int VEC_W = 8
) (
  input  logic [CW-1:0]    c,
  input  logic [VEC_W-1:0] n,
  output logic             en
);
  localparam logic [CW-1:0] LO = CW'(R * STEP);

  logic [CW-1:0] last;

  assign last = CW'((R + int'(n) + COLS - 1) * STEP - 1);
  assign en   = (c >= LO) && (c <= last);
endmodule

// File: rtl/systolic_scheduler_v2.sv
// Weight-load / skewed-wavefront sequencer for the systolic array.
// Next state and next outputs are formed combinationally and registered
// together, so every output reflects the state of the current cycle.
module systolic_scheduler_v2
  import systolic_sched_pkg::*;
#(
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int STEP  = 4,
  parameter int VEC_W = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  systolic_scheduler_v2_if.slave bus
);
  localparam int CW = cnt_width(ROWS, COLS, STEP, VEC_W);
  localparam int PW = (STEP > 1) ? $clog2(STEP) : 1;

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_LOAD    = LOAD;
  localparam logic [1:0] ST_COMPUTE = COMPUTE;
  localparam logic [1:0] ST_DONE    = DONE;

  localparam logic [CW-1:0] ROWS_M1 = CW'(ROWS - 1);
  localparam logic [PW-1:0] STEP_M1 = PW'(STEP - 1);

  logic [1:0]       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;     // load row index or compute counter c
  logic [PW-1:0]    ph, ph_nx;       // position of c within the current step
  logic [VEC_W-1:0] nv, nv_nx;       // latched num_vec
  logic [CW-1:0]    t_last, vr_last;

  logic [ROWS-1:0]  lw_nx, em_nx, em_win;
  logic             vr_nx;

  logic [ROWS-1:0]  lw_q, em_q;
  logic             vr_q, busy_q, done_q;

  assign t_last  = CW'(calc_t(int'(nv), ROWS, COLS, STEP) - 1);
  assign vr_last = CW'(int'(nv_nx) * STEP - 1);

  // FSM / counter advance; abort wins over everything, stall holds all state
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ph_nx    = ph;
    nv_nx    = nv;
    if (bus.abort) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
      ph_nx    = '0;
      nv_nx    = '0;
    end else if (bus.general_enable) begin
      case (state)
        ST_IDLE: if (bus.start) begin
          state_nx = ST_LOAD;
          cnt_nx   = '0;
          ph_nx    = '0;
          nv_nx    = bus.num_vec;
        end
        ST_LOAD: if (cnt == ROWS_M1) begin
          state_nx = (nv != '0) ? ST_COMPUTE : ST_DONE;
          cnt_nx   = '0;
          ph_nx    = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
        ST_COMPUTE: if (cnt == t_last) begin
          state_nx = ST_DONE;
          cnt_nx   = '0;
          ph_nx    = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
          ph_nx  = (ph == STEP_M1) ? '0 : ph + PW'(1);
        end
        default: begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
          ph_nx    = '0;
        end
      endcase
    end
  end

  // Per-row strobes for the upcoming cycle
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    row_window_gen #(
      .R(r), .COLS(COLS), .STEP(STEP), .CW(CW), .VEC_W(VEC_W)
    ) u_win (
      .c  (cnt_nx),
      .n  (nv_nx),
      .en (em_win[r])
    );
    assign lw_nx[r] = (state_nx == ST_LOAD) && (cnt_nx == CW'(r));
    assign em_nx[r] = (state_nx == ST_COMPUTE) && em_win[r];
  end

  assign vr_nx = (state_nx == ST_COMPUTE) && (ph_nx == '0) && (cnt_nx <= vr_last);

  // State and counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      ph    <= '0;
      nv    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ph    <= ph_nx;
      nv    <= nv_nx;
    end
  end

  // Registered outputs; strobes are forced low while stalled or aborting.
  // busy tracks the held state, so it naturally holds through a stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lw_q   <= '0;
      em_q   <= '0;
      vr_q   <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_nx != ST_IDLE);
      if (bus.abort || !bus.general_enable) begin
        lw_q   <= '0;
        em_q   <= '0;
        vr_q   <= 1'b0;
        done_q <= 1'b0;
      end else begin
        lw_q   <= lw_nx;
        em_q   <= em_nx;
        vr_q   <= vr_nx;
        done_q <= (state_nx == ST_DONE);
      end
    end
  end

  assign bus.load_weight = lw_q;
  assign bus.enable_mult = em_q;
  assign bus.vec_req     = vr_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_systolic_scheduler_v2.sv
// Directed bench for systolic_scheduler_v2 (ROWS=COLS=2, STEP=4).
// Observed vector per cycle: {busy, done, vec_req, enable_mult[1:0], load_weight[1:0]}.
module tb_systolic_scheduler_v2;
  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;

  systolic_scheduler_v2_if #(.ROWS(2), .VEC_W(8)) bus ();

  systolic_scheduler_v2 #(.ROWS(2), .COLS(2), .STEP(4), .VEC_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] obs();
    return {bus.busy, bus.done, bus.vec_req, bus.enable_mult, bus.load_weight};
  endfunction

  // Hand-derived timeline for num_vec=3, start accepted at edge 0:
  // load 01@1, 10@2; em0 3..18; em1 7..22; vec_req 3,7,11; done 23; busy 1..23.
  function automatic logic [6:0] exp_base(int cy);
    logic       b, d, v;
    logic [1:0] e, l;
    b = (cy >= 1) && (cy <= 23);
    d = (cy == 23);
    v = (cy == 3) || (cy == 7) || (cy == 11);
    e = {(cy >= 7) && (cy <= 22), (cy >= 3) && (cy <= 18)};
    l = {(cy == 2), (cy == 1)};
    return {b, d, v, e, l};
  endfunction

  task automatic chk(input string tag, input int cy, input logic [6:0] o, input logic [6:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cy, o, e);
    end
  endtask

  // Start is sampled at the next edge (edge 0); returns in cycle 1.
  task automatic do_start(input logic [7:0] n);
    bus.num_vec = n;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  initial begin
    reset_n            = 1'b0;
    bus.general_enable = 1'b1;
    bus.start          = 1'b0;
    bus.abort          = 1'b0;
    bus.num_vec        = '0;
    tick();
    tick();
    chk("reset", 0, obs(), 7'b0);
    reset_n = 1'b1;
    tick();
    chk("idle_after_reset", 0, obs(), 7'b0);

    // 1: basic run, num_vec=3
    do_start(8'd3);
    for (int cy = 1; cy <= 25; cy++) begin
      chk("run_n3", cy, obs(), exp_base(cy));
      tick();
    end

    // 2: num_vec=0 skips compute
    do_start(8'd0);
    chk("n0_load0", 1, obs(), 7'b1000001);
    tick();
    chk("n0_load1", 2, obs(), 7'b1000010);
    tick();
    chk("n0_done", 3, obs(), 7'b1100000);
    tick();
    chk("n0_idle", 4, obs(), 7'b0000000);
    tick();

    // 3: 5-cycle stall starting at compute c=6 (cycle 9)
    do_start(8'd3);
    for (int cy = 1; cy <= 29; cy++) begin
      if (cy <= 9)       chk("stall", cy, obs(), exp_base(cy));
      else if (cy <= 14) chk("stall", cy, obs(), 7'b1000000);
      else               chk("stall", cy, obs(), exp_base(cy - 5));
      if (cy == 9)  bus.general_enable = 1'b0;
      if (cy == 14) bus.general_enable = 1'b1;
      tick();
    end

    // 4: abort at compute c=10 (cycle 13)
    do_start(8'd3);
    for (int cy = 1; cy <= 13; cy++) begin
      chk("pre_abort", cy, obs(), exp_base(cy));
      if (cy < 13) tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    for (int cy = 14; cy <= 25; cy++) begin
      chk("post_abort", cy, obs(), 7'b0);
      tick();
    end

    // 5: start re-asserted in LOAD and in the DONE cycle is ignored
    do_start(8'd3);
    for (int cy = 1; cy <= 26; cy++) begin
      chk("restart_ign", cy, obs(), exp_base(cy));
      if (cy == 1 || cy == 23) bus.start = 1'b1;
      if (cy == 2 || cy == 24) bus.start = 1'b0;
      tick();
    end

    // 6: asynchronous reset mid-compute
    do_start(8'd3);
    for (int cy = 1; cy <= 10; cy++) begin
      chk("pre_reset", cy, obs(), exp_base(cy));
      if (cy < 10) tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 10, obs(), 7'b0);
    tick();
    reset_n = 1'b1;
    for (int cy = 0; cy < 3; cy++) begin
      tick();
      chk("idle_post_reset", cy, obs(), 7'b0);
    end

    // Block still works after reset
    do_start(8'd0);
    chk("rerun_load0", 1, obs(), 7'b1000001);
    tick();
    tick();
    chk("rerun_done", 3, obs(), 7'b1100000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/systolic_scheduler_v2.md
Name: systolic_scheduler_v2

Overview:
Next-generation control sequencer for the systolic multiply array. It loads weights row by row, then runs a skewed, per-row multiply wavefront for a runtime-selectable number of input vectors. It requests input vectors at the wavefront step rate and signals completion with a start/busy/done handshake. It sits between the host/DMA controller and the PE grid, and drives the per-row load_weight and enable_mult strobes.

Parameters:
ROWS, 2, number of PE rows (≥1)
COLS, 2, number of PE columns (≥1)
STEP, 4, cycles per wavefront step, i.e. PE pipeline latency (≥1)
VEC_W, 8, width of num_vec; maximum vectors per run is 2^VEC_W-1

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  reset, asynchronous and active-low
general_enable  in  1  global stall; 0 freezes all state
start  in  1  run request, sampled in IDLE only
abort  in  1  synchronous cancel, any state
num_vec  in  VEC_W  vectors to stream, latched on start acceptance
load_weight  out  ROWS  one-hot per-row weight load strobe
enable_mult  out  ROWS  per-row multiply enable
vec_req  out  1  one-cycle pulse requesting the next input vector
busy  out  1  high from start acceptance to the done cycle
done  out  1  one-cycle completion pulse

Behaviour:
- All outputs are registered.
- Reset (reset_n=0, asynchronous):
  - state=IDLE; all counters 0.
  - load_weight=0, enable_mult=0, vec_req=0, busy=0, done=0.
- FSM states: IDLE, LOAD, COMPUTE, DONE.
- Stall rule: while general_enable=0, state and counters hold, and load_weight, enable_mult, vec_req and done are driven 0. busy holds.
  - A done pulse due during a stall is deferred until general_enable returns.
- IDLE:
  - When start=1 and general_enable=1 at an edge, latch num_vec, go to LOAD, and set busy=1 in the next cycle.
  - start in any other state is ignored.
- LOAD:
  - Lasts exactly ROWS enabled cycles.
  - In load cycle i (0..ROWS-1), load_weight has only bit i set. enable_mult=0.
  - After the last load cycle: go to COMPUTE if latched num_vec≠0, otherwise go directly to DONE.
- COMPUTE:
  - Compute counter c runs from 0 to T-1, where T=(N+ROWS+COLS-2)*STEP and N is the latched num_vec.
  - enable_mult[r]=1 iff r*STEP ≤ c < (r+N+COLS-1)*STEP.
  - vec_req=1 iff c=k*STEP for some k in 0..N-1.
  - After c=T-1, go to DONE.
- DONE:
  - One cycle with done=1 and busy=1.
  - Next state is IDLE, where busy=0 and done=0.
  - A start asserted in the DONE cycle is ignored; start is accepted from the following IDLE cycle.
- abort=1 at any edge:
  - Next state is IDLE; all outputs 0 and counters 0.
  - No done pulse is issued.
  - abort has priority over start and general_enable.
- Widths:
  - c is sized to hold (2^VEC_W-1+ROWS+COLS-2)*STEP-1, using $clog2 of that bound.
  - All comparisons are unsigned and no wrap-around occurs.
  - Window bounds are computed in the same width as c.
- Reset asserted mid-operation: immediate return to the reset values, independent of clk.
- ROWS=1 and STEP=1 are legal:
  - A single load cycle.
  - vec_req fires on every one of the first N compute cycles.

Decomposition:
- Package systolic_sched_pkg holds:
  - the state enum (IDLE, LOAD, COMPUTE, DONE);
  - a function computing the counter width from ROWS, COLS, STEP and VEC_W;
  - a function computing T.
- Sub-module row_window_gen is natural. Given c, N, row index r, COLS and STEP, it combinationally produces enable_mult[r]. It is instantiated ROWS times via generate, and the top module registers the outputs.

Test Plan:
1. ROWS=COLS=2, STEP=4, num_vec=3, start accepted at edge 0 -> load_weight=01 in cycle 1 and 10 in cycle 2; COMPUTE cycles 3..22; enable_mult[0] high cycles 3..18, enable_mult[1] high cycles 7..22; vec_req in cycles 3, 7, 11; done in cycle 23; busy high in cycles 1..23.
2. Same setup with num_vec=0 -> two load cycles, done in cycle 3, no enable_mult and no vec_req.
3. general_enable held low for 5 cycles starting at compute c=6 -> all strobes 0 during the stall; the timeline resumes exactly and done arrives 5 cycles later (cycle 28).
4. abort at compute c=10 -> next cycle all outputs 0 and state IDLE; no done; a new start is then accepted normally.
5. start re-asserted during LOAD and during the DONE cycle -> ignored; the run completes once with a single done pulse.
6. reset_n pulled low asynchronously mid-COMPUTE (between edges) -> outputs drop to 0 without a clock edge; the block is idle after release.
